cp0_timer_ctrl: RTL and testbench

CP0_TIMER_CTRL -- requirements
Module: cp0_timer_ctrl

---
 rtl/cp0_timer_ctrl_pkg.sv | 9 +
 rtl/cp0_timer_ctrl.sv | 85 ++++++++
 tb/tb_cp0_timer_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared CP0 definitions for the Count/Compare timer: register addresses and reset values.
package cp0_timer_ctrl_pkg;

  localparam logic [5:0]  cp0addr_Count   = 6'd9;
  localparam logic [5:0]  cp0addr_Compare = 6'd11;
  localparam logic [31:0] Count_ini       = 32'h0000_0000;
  localparam logic [31:0] Compare_ini     = 32'h0000_0000;

endpackage

// File: rtl/cp0_timer_ctrl.sv
// CP0 Count/Compare timer with registered timer interrupt.
// CP0_COUNT_HALF_RATE_EN selects half-rate Count (one increment per two enabled cycles).
module cp0_timer_ctrl
  import cp0_timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mtc0_we,
  input  logic        exception,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic        count_dis,
  output logic [31:0] cp0_count_data,
  output logic [31:0] cp0_compare_data,
  output logic        timer_int
);

  logic        wr;
  logic        wr_count;
  logic        wr_compare;
  logic        inc;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] count_plus1;
  logic        ti_q;

  // A faulting commit cancels its MTC0 write.
  assign wr          = mtc0_we & ~exception;
  assign wr_count    = wr & (cp0_addr == cp0addr_Count);
  assign wr_compare  = wr & (cp0_addr == cp0addr_Compare);
  assign count_plus1 = count_q + 32'd1;

`ifdef CP0_COUNT_HALF_RATE_EN
  logic tick_q;

  // Writing Count restarts the divider so the next increment lands two cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else if (wr_count) begin
      tick_q <= 1'b0;
    end else if (!count_dis) begin
      tick_q <= ~tick_q;
    end
  end

  assign inc = ~count_dis & tick_q;
`else
  assign inc = ~count_dis;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= Count_ini;
    end else if (wr_count) begin
      count_q <= mtc0_data;
    end else if (inc) begin
      count_q <= count_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compare_q <= Compare_ini;
    end else if (wr_compare) begin
      compare_q <= mtc0_data;
    end
  end

  // Compare write clears the interrupt and beats a match in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ti_q <= 1'b0;
    end else if (wr_compare) begin
      ti_q <= 1'b0;
    end else if (inc && !wr_count && (count_plus1 == compare_q)) begin
      ti_q <= 1'b1;
    end
  end

  assign cp0_count_data   = count_q;
  assign cp0_compare_data = compare_q;
  assign timer_int        = ti_q;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Self-checking bench for cp0_timer_ctrl: directed scenarios plus random MTC0 traffic vs. a model.
module tb_cp0_timer_ctrl;
  import cp0_timer_ctrl_pkg::*;

`ifdef CP0_COUNT_HALF_RATE_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  localparam logic [5:0] ADDR_OTHER = 6'd12;

  logic        clk;
  logic        rst_n;
  logic        mtc0_we;
  logic        exception;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        count_dis;
  logic [31:0] cp0_count_data;
  logic [31:0] cp0_compare_data;
  logic        timer_int;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: Count, Compare, interrupt, and enabled cycles since the last Count restart.
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_ti;
  int          m_en;

  cp0_timer_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mtc0_we          (mtc0_we),
    .exception        (exception),
    .cp0_addr         (cp0_addr),
    .mtc0_data        (mtc0_data),
    .count_dis        (count_dis),
    .cp0_count_data   (cp0_count_data),
    .cp0_compare_data (cp0_compare_data),
    .timer_int        (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the timer rules to the reference for the edge just taken.
  task automatic model_edge();
    logic wr_c, wr_p, bump;
    if (!rst_n) begin
      m_count = 32'h0;
      m_cmp   = 32'h0;
      m_ti    = 1'b0;
      m_en    = 0;
    end else begin
      wr_c = mtc0_we && !exception && (cp0_addr == cp0addr_Count);
      wr_p = mtc0_we && !exception && (cp0_addr == cp0addr_Compare);
      bump = !count_dis && (HALF ? (m_en % 2 == 1) : 1'b1);
      if (wr_c) begin
        m_count = mtc0_data;
        m_en    = 0;
      end else if (!count_dis) begin
        if (bump) begin
          if (m_count + 32'd1 == m_cmp) m_ti = 1'b1;
          m_count = m_count + 32'd1;
        end
        m_en++;
      end
      if (wr_p) begin
        m_cmp = mtc0_data;
        m_ti  = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},   cp0_count_data,   m_count);
    chk({tag, ".compare"}, cp0_compare_data, m_cmp);
    chk({tag, ".ti"},      {31'd0, timer_int}, {31'd0, m_ti});
  endtask

  task automatic cycle(input logic we, input logic exc, input logic [5:0] addr,
                       input logic [31:0] data, input logic dis, input string tag);
    mtc0_we   = we;
    exception = exc;
    cp0_addr  = addr;
    mtc0_data = data;
    count_dis = dis;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b0, tag);
  endtask

  initial begin
    logic [5:0]  ra;
    logic [31:0] rd;
    int          sel;
    rst_n = 1'b0;
    m_count = 32'hx; m_cmp = 32'hx; m_ti = 1'bx; m_en = 0;
    // Reset holds even against a concurrent Count write.
    cycle(1'b1, 1'b0, cp0addr_Count, 32'h1234_5678, 1'b0, "reset0");
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h5, 1'b0, "reset1");
    chk("reset.count_zero", cp0_count_data, 32'h0);
    chk("reset.ti_zero", {31'd0, timer_int}, 32'h0);
    rst_n = 1'b1;

    idle(5, "run_after_reset");

    // Count=0x0A then Compare=0x0C: interrupt on reaching 0x0C, sticky afterwards.
    cycle(1'b1, 1'b0, cp0addr_Count, 32'h0000_000A, 1'b0, "wr_count_a");
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_000C, 1'b0, "wr_compare_c");
    idle(8, "run_to_match");
    chk("match.ti_sticky", {31'd0, timer_int}, 32'h1);

    // Compare write clears the interrupt.
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_0100, 1'b0, "clear_ti");
    chk("clear.ti_zero", {31'd0, timer_int}, 32'h0);

    // Compare write colliding with a matching increment: clear wins.
    cycle(1'b1, 1'b0, cp0addr_Count, 32'h0000_0020, 1'b0, "wr_count_20");
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_0021, 1'b0, "wr_compare_21");
    for (int i = 0; i < 4; i++) begin
      if (!HALF || i == 0)
        cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_0021, 1'b0, "collide");
      else
        idle(1, "collide_idle");
    end

    // Count write equal to Compare does not raise the interrupt.
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_0040, 1'b0, "wr_compare_40");
    cycle(1'b1, 1'b0, cp0addr_Count, 32'h0000_0040, 1'b0, "wr_count_eq");
    chk("count_eq.no_ti", {31'd0, timer_int}, 32'h0);

    // Wrap from 0xFFFFFFFF to 0 with Compare=0.
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'h0000_0000, 1'b0, "wr_compare_0");
    cycle(1'b1, 1'b0, cp0addr_Count, 32'hFFFF_FFFF, 1'b0, "wr_count_max");
    idle(3, "wrap");
    chk("wrap.ti_set", {31'd0, timer_int}, 32'h1);

    // Cancelled and unrelated writes change nothing.
    cycle(1'b1, 1'b1, cp0addr_Compare, 32'h0000_0055, 1'b0, "exc_compare");
    cycle(1'b1, 1'b1, cp0addr_Count, 32'h0000_0055, 1'b0, "exc_count");
    cycle(1'b1, 1'b0, ADDR_OTHER, 32'h0000_0055, 1'b0, "other_addr");
    chk("cancel.ti_kept", {31'd0, timer_int}, 32'h1);

    // Freeze for 10 cycles from an odd phase, then resume.
    cycle(1'b1, 1'b0, cp0addr_Count, 32'h0000_0300, 1'b0, "wr_count_300");
    idle(1, "phase");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, ADDR_OTHER, 32'h0, 1'b1, "frozen");
    idle(5, "resume");

    // Random traffic, with Compare often placed just ahead of Count to provoke matches.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      ra  = (sel < 3) ? cp0addr_Count : (sel < 6) ? cp0addr_Compare : 6'($urandom_range(0, 63));
      rd  = ($urandom_range(0, 1) == 1) ? m_count + 32'($urandom_range(1, 6)) : $urandom;
      if ($urandom_range(0, 3) == 0) rd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, ra, rd,
            $urandom_range(0, 5) == 0, "random");
    end

    // Reset in the middle of activity.
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, cp0addr_Compare, 32'hDEAD_BEEF, 1'b0, "mid_reset");
    rst_n = 1'b1;
    idle(3, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
